// File: rtl/mavg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : mavg_ctrl_pkg
// Desc   : Shared state type, mode codes and window helpers for the
//          moving-average stream controller.
// Rev    : 1.0  initial release
// ============================================================================
package mavg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ctrl_state_e;

    localparam logic [2:0] MODE_PASS      = 3'b000;
    localparam logic [2:0] MODE_AVG2      = 3'b001;
    localparam logic [2:0] MODE_AVG3      = 3'b010;
    localparam logic [2:0] MODE_AVG4      = 3'b011;
    localparam logic [2:0] MODE_AVG16     = 3'b100;
    localparam logic [2:0] MODE_AVG16_ALT = 3'b101;

    localparam int BUF_DEPTH = 2;
    localparam int WARM_W    = 4;

    function automatic logic [4:0] win_len(input logic [2:0] mode);
        logic [4:0] len;
        case (mode)
            MODE_PASS:                  len = 5'd1;
            MODE_AVG2:                  len = 5'd2;
            MODE_AVG3:                  len = 5'd3;
            MODE_AVG4:                  len = 5'd4;
            MODE_AVG16, MODE_AVG16_ALT: len = 5'd16;
            default:                    len = 5'd1;
        endcase
        return len;
    endfunction

    // Number of results to throw away before the window is fully populated.
    function automatic logic [WARM_W-1:0] warm_init(input logic [2:0] mode);
        logic [4:0] cnt;
        cnt = win_len(mode) - 5'd1;
        return cnt[WARM_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mavg_out_buf.sv
`default_nettype none
// ============================================================================
// Module : mavg_out_buf
// Desc   : Two-entry valid/ready result FIFO; reports free entries so the
//          issuer can reserve space before a sample is sent to the engine.
// Rev    : 1.0  initial release
// ============================================================================
module mavg_out_buf
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [1:0]            free_entries_o,
    output logic                  empty_o
);
    import mavg_ctrl_pkg::*;

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic [1:0]            count_d;
    logic                  pop;

    assign empty_o        = (count_q == 2'd0);
    assign m_valid_o      = !empty_o;
    assign m_data_o       = mem_q[rd_ptr_q];
    assign free_entries_o = 2'(DEPTH) - count_q;
    assign pop            = m_valid_o && m_ready_i;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mavg_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mavg_stream_ctrl
// Desc   : Sequencer between a valid/ready sample stream and the moving-average
//          engine: issues strobes, applies config at safe points, discards
//          warm-up results and buffers outputs. Optional statistics counters
//          are compiled in with MAVG_STREAM_CTRL_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module mavg_stream_ctrl
#(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_DEPTH  = mavg_ctrl_pkg::BUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [2:0]            cfg_mode,
    input  logic                  cfg_refresh_mode,
    input  logic                  cfg_flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  eng_enable,
    output logic                  eng_data_refresh,
    output logic [DATA_WIDTH-1:0] eng_din,
    output logic [2:0]            eng_mode,
    output logic                  eng_output_refresh_mode,
    input  logic [DATA_WIDTH-1:0] eng_dout,
    input  logic                  eng_output_pulse,
    output logic                  busy
`ifdef MAVG_STREAM_CTRL_STATS_EN
    ,
    output logic [31:0]           stat_samples,
    output logic [31:0]           stat_results,
    output logic [31:0]           stat_discards
`endif
);
    import mavg_ctrl_pkg::*;

    ctrl_state_e           state_q, state_d;
    logic [2:0]            mode_q, mode_d;
    logic                  orm_q, orm_d;
    logic [WARM_W-1:0]     warm_q, warm_d;
    logic                  refresh_q, refresh_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  inflight_q;

    logic [1:0]            free_entries;
    logic                  buf_empty;
    logic                  has_credit;
    logic                  push;

    // A slot is reserved for every sample still in the engine pipeline, both
    // the one being strobed now and the one whose result is due this cycle.
    assign has_credit = {1'b0, free_entries} >
                        ({2'b00, inflight_q} + {2'b00, refresh_q});

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        orm_d     = orm_q;
        warm_d    = warm_q;
        refresh_d = 1'b0;
        din_d     = din_q;
        s_ready   = 1'b0;
        cfg_ready = 1'b0;
        push      = 1'b0;

        if (inflight_q) begin
            if (warm_q != '0) begin
                warm_d = warm_q - 1'b1;
            end else if (eng_output_pulse) begin
                push = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    mode_d  = cfg_mode;
                    orm_d   = cfg_refresh_mode;
                    warm_d  = warm_init(cfg_mode);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_ready = !cfg_valid && has_credit;
                if (cfg_valid) begin
                    state_d = ST_DRAIN;
                end else if (s_valid && has_credit) begin
                    refresh_d = 1'b1;
                    din_d     = s_data;
                end
            end
            ST_DRAIN: begin
                cfg_ready = !inflight_q;
                if (cfg_valid && !inflight_q) begin
                    mode_d = cfg_mode;
                    orm_d  = cfg_refresh_mode;
                    if (cfg_flush) begin
                        warm_d = warm_init(cfg_mode);
                    end
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= 3'b000;
            orm_q      <= 1'b0;
            warm_q     <= '0;
            refresh_q  <= 1'b0;
            din_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            orm_q      <= orm_d;
            warm_q     <= warm_d;
            refresh_q  <= refresh_d;
            din_q      <= din_d;
            inflight_q <= refresh_q;
        end
    end

    mavg_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_out_buf (
        .clk            (clk),
        .rst_n          (rst_n),
        .push_i         (push),
        .push_data_i    (eng_dout),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready),
        .m_data_o       (m_data),
        .free_entries_o (free_entries),
        .empty_o        (buf_empty)
    );

    assign eng_enable              = (state_q != ST_IDLE);
    assign eng_data_refresh        = refresh_q;
    assign eng_din                 = din_q;
    assign eng_mode                = mode_q;
    assign eng_output_refresh_mode = orm_q;
    assign busy                    = (state_q != ST_IDLE) || inflight_q || !buf_empty;

`ifdef MAVG_STREAM_CTRL_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_samples_q;
    logic [31:0] stat_results_q;
    logic [31:0] stat_discards_q;

    assign stat_clr = cfg_valid && cfg_ready && cfg_flush;

    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            stat_samples_q  <= '0;
            stat_results_q  <= '0;
            stat_discards_q <= '0;
        end else begin
            if (refresh_q && (stat_samples_q != '1)) begin
                stat_samples_q <= stat_samples_q + 32'd1;
            end
            if (push && (stat_results_q != '1)) begin
                stat_results_q <= stat_results_q + 32'd1;
            end
            if (inflight_q && !push && (stat_discards_q != '1)) begin
                stat_discards_q <= stat_discards_q + 32'd1;
            end
        end
    end

    assign stat_samples  = stat_samples_q;
    assign stat_results  = stat_results_q;
    assign stat_discards = stat_discards_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mavg_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mavg_stream_ctrl
// Desc   : Self-checking bench with a behavioural engine and a queue-based
//          reference model of the controller's result stream.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mavg_stream_ctrl;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_mode;
    logic        cfg_refresh_mode;
    logic        cfg_flush;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        eng_enable;
    logic        eng_data_refresh;
    logic [15:0] eng_din;
    logic [2:0]  eng_mode;
    logic        eng_output_refresh_mode;
    logic [15:0] eng_dout;
    logic        eng_output_pulse;
    logic        busy;
`ifdef MAVG_STREAM_CTRL_STATS_EN
    logic [31:0] stat_samples;
    logic [31:0] stat_results;
    logic [31:0] stat_discards;
`endif

    int          n_vec = 0;
    int          n_err = 0;

    logic [15:0] exp_q[$];
    int          rhist[$];
    int          ehist[$];
    bit          configured;
    int          m_warm;
    logic [2:0]  m_mode;
    logic        m_orm;

    mavg_stream_ctrl #(
        .DATA_WIDTH (16),
        .BUF_DEPTH  (2)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .s_valid                 (s_valid),
        .s_ready                 (s_ready),
        .s_data                  (s_data),
        .cfg_valid               (cfg_valid),
        .cfg_ready               (cfg_ready),
        .cfg_mode                (cfg_mode),
        .cfg_refresh_mode        (cfg_refresh_mode),
        .cfg_flush               (cfg_flush),
        .m_valid                 (m_valid),
        .m_ready                 (m_ready),
        .m_data                  (m_data),
        .eng_enable              (eng_enable),
        .eng_data_refresh        (eng_data_refresh),
        .eng_din                 (eng_din),
        .eng_mode                (eng_mode),
        .eng_output_refresh_mode (eng_output_refresh_mode),
        .eng_dout                (eng_dout),
        .eng_output_pulse        (eng_output_pulse),
        .busy                    (busy)
`ifdef MAVG_STREAM_CTRL_STATS_EN
        ,
        .stat_samples            (stat_samples),
        .stat_results            (stat_results),
        .stat_discards           (stat_discards)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int win_of(input logic [2:0] mode);
        case (mode)
            3'd1:       return 2;
            3'd2:       return 3;
            3'd3:       return 4;
            3'd4, 3'd5: return 16;
            default:    return 1;
        endcase
    endfunction

    // Average of the newest win_of(mode) samples, newest first in h.
    function automatic logic [15:0] window_avg(input int h[$], input logic [2:0] mode);
        int n;
        int sum;
        n   = win_of(mode);
        sum = 0;
        for (int i = 0; i < n && i < h.size(); i++) sum += h[i];
        case (n)
            2:       sum = sum >>> 1;
            3:       sum = sum / 3;
            4:       sum = sum >>> 2;
            16:      sum = sum >>> 4;
            default: sum = sum;
        endcase
        return sum[15:0];
    endfunction

    function automatic logic [15:0] rnd_sample();
        int v;
        v = int'($urandom_range(2000)) - 1000;
        return v[15:0];
    endfunction

    // Behavioural engine: result one cycle after the strobe; when
    // output_refresh_mode is 0 it only emits results for even samples.
    always @(posedge clk) begin
        if (!rst_n) begin
            ehist.delete();
            eng_dout         <= '0;
            eng_output_pulse <= 1'b0;
        end else if (eng_enable && eng_data_refresh) begin
            ehist.push_front(int'($signed(eng_din)));
            if (ehist.size() > 16) void'(ehist.pop_back());
            eng_dout         <= window_avg(ehist, eng_mode);
            eng_output_pulse <= eng_output_refresh_mode || !eng_din[0];
        end else begin
            eng_output_pulse <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: handshakes are observed mid-cycle and take effect at
    // the following rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            rhist.delete();
            configured = 1'b0;
            m_warm     = 0;
            m_mode     = 3'd0;
            m_orm      = 1'b0;
        end else begin
            if (cfg_valid && cfg_ready) begin
                if (!configured || cfg_flush) m_warm = win_of(cfg_mode) - 1;
                configured = 1'b1;
                m_mode     = cfg_mode;
                m_orm      = cfg_refresh_mode;
            end
            if (s_valid && s_ready) begin
                rhist.push_front(int'($signed(s_data)));
                if (rhist.size() > 16) void'(rhist.pop_back());
                if (m_warm > 0) m_warm--;
                else if (m_orm || !s_data[0]) exp_q.push_back(window_avg(rhist, m_mode));
            end
            if (m_valid && m_ready) begin
                check("m_has_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("m_data", m_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        bit got = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            got = s_ready;
            tick();
        end
        s_valid = 1'b0;
        check("send_timeout", got, 1);
    endtask

    task automatic do_cfg(input logic [2:0] md, input logic rm, input logic fl);
        bit got = 1'b0;
        cfg_valid        = 1'b1;
        cfg_mode         = md;
        cfg_refresh_mode = rm;
        cfg_flush        = fl;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            got = cfg_ready;
            tick();
        end
        cfg_valid = 1'b0;
        cfg_flush = 1'b0;
        check("cfg_timeout", got, 1);
        check("cfg_eng_mode", eng_mode, md);
        check("cfg_eng_orm", eng_output_refresh_mode, rm);
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !m_valid;
            tick();
        end
        check("drain_timeout", done, 1);
    endtask

    initial begin
        int  acc;
        bit  hs;

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; cfg_valid = 1'b0;
        cfg_mode = 3'd0; cfg_refresh_mode = 1'b0; cfg_flush = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_eng_enable", eng_enable, 0);
        check("rst_eng_refresh", eng_data_refresh, 0);
        check("rst_eng_din", eng_din, 0);
        check("rst_eng_mode", eng_mode, 0);
        check("rst_eng_orm", eng_output_refresh_mode, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Pass-through mode and two-edge latency.
        m_ready = 1'b1;
        do_cfg(3'd0, 1'b1, 1'b0);
        check("run_eng_enable", eng_enable, 1);
        send(16'd5);
        check("lat_edge0", m_valid, 0);
        tick();
        check("lat_edge1", m_valid, 0);
        tick();
        check("lat_edge2", m_valid, 1);
        check("lat_data", m_data, 16'd5);
        send(16'hFFFD);
        send(16'd7);
        wait_drain();

        // Four-tap average with warm-up discards: expect 10 then 14.
        do_cfg(3'd3, 1'b1, 1'b1);
        send(16'd4); send(16'd8); send(16'd12); send(16'd16); send(16'd20);
        wait_drain();
`ifdef MAVG_STREAM_CTRL_STATS_EN
        check("stat_samples", stat_samples, 5);
        check("stat_results", stat_results, 2);
        check("stat_discards", stat_discards, 3);
`endif

        // Back-pressure: only two samples fit while the consumer stalls.
        m_ready = 1'b0;
        acc     = 0;
        s_valid = 1'b1;
        s_data  = rnd_sample();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hs = s_ready;
            tick();
            if (hs) begin
                acc++;
                s_data = rnd_sample();
            end
        end
        @(negedge clk);
        check("bp_accepted", acc, 2);
        check("bp_s_ready", s_ready, 0);
        check("bp_m_valid", m_valid, 1);
        tick();
        s_valid = 1'b0;
        wait_drain();

        // Config request collides with a sample; drain waits for the result.
        s_valid = 1'b1;
        s_data  = rnd_sample();
        @(negedge clk);
        check("coll_first_ready", s_ready, 1);
        tick();
        s_data = rnd_sample();
        cfg_valid = 1'b1; cfg_mode = 3'd1; cfg_refresh_mode = 1'b1; cfg_flush = 1'b0;
        @(negedge clk);
        check("coll_cfg_wins", s_ready, 0);
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        check("drain_cfg_wait", cfg_ready, 0);
        check("drain_no_refresh0", eng_data_refresh, 0);
        tick();
        @(negedge clk);
        check("drain_cfg_ready", cfg_ready, 1);
        check("drain_no_refresh1", eng_data_refresh, 0);
        check("drain_s_ready", s_ready, 0);
        tick();
        cfg_valid = 1'b0;
        check("drain_mode_upd", eng_mode, 3'd1);
        send(rnd_sample());
        wait_drain();

        // 16-tap warm-up, interrupted by a non-flushing reconfiguration.
        do_cfg(3'd5, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send(rnd_sample());
        do_cfg(3'd5, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) send(rnd_sample());
        wait_drain();
        do_cfg(3'd4, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send(rnd_sample());
        wait_drain();

        // Decimated output, then the three-tap mode.
        do_cfg(3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send(rnd_sample());
        wait_drain();
        do_cfg(3'd2, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) send(rnd_sample());
        wait_drain();

        // Random traffic with occasional reconfiguration.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            hs = cfg_valid && cfg_ready;
            tick();
            if (hs) begin
                cfg_valid = 1'b0;
            end else if (!cfg_valid && $urandom_range(39) == 0) begin
                cfg_valid        = 1'b1;
                cfg_mode         = 3'($urandom_range(7));
                cfg_refresh_mode = 1'($urandom_range(1));
                cfg_flush        = 1'($urandom_range(1));
            end
            s_valid = 1'($urandom_range(1));
            s_data  = rnd_sample();
            m_ready = ($urandom_range(3) != 0);
        end
        s_valid   = 1'b0;
        cfg_valid = 1'b0;
        wait_drain();

        // Reset while a result is buffered and another is in flight.
        do_cfg(3'd0, 1'b1, 1'b1);
        m_ready = 1'b0;
        send(rnd_sample());
        tick();
        send(rnd_sample());
        tick();
        check("pre_rst_m_valid", m_valid, 1);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_s_ready", s_ready, 0);
        check("mid_rst_eng_enable", eng_enable, 0);
        check("mid_rst_cfg_ready", cfg_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_refresh", eng_data_refresh, 0);
        check("mid_rst_m_data", m_data, 0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
